// File: rtl/clk_tick_gen_if.sv
// Control/tick bundle between a clock-tick generator and its consumer.
// Latency: none; plain wires grouped for port hygiene.
// Backpressure: none; ticks are single-cycle strobes with no ready.
interface clk_tick_gen_if #(
   parameter int NUM_CH = 8,
   parameter int SEL_W  = 4,
   parameter int DIV_W  = 16
);
   logic                    en_i;
   logic                    sync_i;
   logic                    cfg_we_i;
   logic [NUM_CH*SEL_W-1:0] cfg_sel_i;
   logic [NUM_CH-1:0]       cfg_chen_i;
   logic [DIV_W-1:0]        cfg_div_i;
   logic                    cfg_pend_o;
   logic [NUM_CH-1:0]       tick_o;
   logic                    div_tick_o;

   // Controller side: drives enable/sync/config, observes ticks.
   modport master (
      output en_i, sync_i, cfg_we_i, cfg_sel_i, cfg_chen_i, cfg_div_i,
      input  cfg_pend_o, tick_o, div_tick_o
   );

   // Generator side.
   modport slave (
      input  en_i, sync_i, cfg_we_i, cfg_sel_i, cfg_chen_i, cfg_div_i,
      output cfg_pend_o, tick_o, div_tick_o
   );
endinterface

// File: rtl/clk_tick_gen.sv
// Clock-enable tick generator: prescaler with per-channel power-of-two taps plus an arbitrary divider.
// Latency: every tick is a flop output loaded from next-state counters (1 cycle after the causing edge).
// Backpressure: none; en_i=0 freezes all state and forces ticks low, sync_i restarts the phase.
module clk_tick_gen #(
   parameter int CNT_W   = 12,
   parameter int NUM_CH  = 8,
   parameter int SEL_W   = 4,
   parameter int DIV_W   = 16,
   parameter int DIV_RST = 0
) (
   input logic           clk,
   input logic           rstn,
   clk_tick_gen_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Reset tap of channel i is i, saturated to the top prescaler bit.
   function automatic logic [NUM_CH*SEL_W-1:0] reset_sel();
      logic [NUM_CH*SEL_W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         v[i*SEL_W +: SEL_W] = (i < CNT_W) ? SEL_W'(i) : SEL_W'(CNT_W - 1);
      end
      return v;
   endfunction

   localparam logic [NUM_CH*SEL_W-1:0] SEL_RST = reset_sel();
   localparam logic [DIV_W-1:0]        DIV_R   = DIV_W'(DIV_RST);

   // True when c[k:0] == 2^k, i.e. bit k set and all lower bits clear.
   // Taps at or beyond the prescaler width never fire.
   function automatic logic tap_hit(input logic [CNT_W-1:0] c, input int k);
      logic bit_k;
      logic low_nz;
      bit_k  = 1'b0;
      low_nz = 1'b0;
      for (int j = 0; j < CNT_W; j++) begin
         if (j == k) bit_k = c[j];
         if (j < k && c[j]) low_nz = 1'b1;
      end
      return bit_k && !low_nz && (k < CNT_W);
   endfunction

   // Prescaler and divider state
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
   // Active configuration
   logic [NUM_CH*SEL_W-1:0] sel_q, sel_d;
   logic [NUM_CH-1:0]       chen_q, chen_d;
   logic [DIV_W-1:0]        div_q, div_d;
   // Pending configuration, waiting for the next wrap
   logic [NUM_CH*SEL_W-1:0] psel_q, psel_d;
   logic [NUM_CH-1:0]       pchen_q, pchen_d;
   logic [DIV_W-1:0]        pdiv_q, pdiv_d;
   logic                    pend_q, pend_d;
   // Registered outputs
   logic [NUM_CH-1:0]       tick_q, tick_d;
   logic                    div_tick_q, div_tick_d;

   logic                    wrap;

   // A wrap only counts on an enabled edge that is not overridden by sync.
   assign wrap = bus.en_i && !bus.sync_i && (cnt_q == CNT_MAX);

   // Next-state: sync beats enable and wrap; config is applied only at wrap or sync
   // so a tap change never lands mid-period and produces a runt pulse.
   always_comb begin
      cnt_d      = cnt_q;
      div_cnt_d  = div_cnt_q;
      sel_d      = sel_q;
      chen_d     = chen_q;
      div_d      = div_q;
      psel_d     = psel_q;
      pchen_d    = pchen_q;
      pdiv_d     = pdiv_q;
      pend_d     = pend_q;
      tick_d     = '0;
      div_tick_d = 1'b0;

      if (bus.cfg_we_i) begin
         psel_d  = bus.cfg_sel_i;
         pchen_d = bus.cfg_chen_i;
         pdiv_d  = bus.cfg_div_i;
      end

      if (bus.sync_i) begin
         // Phase restart: take whatever is pending (or being written now) immediately.
         cnt_d     = '0;
         sel_d     = psel_d;
         chen_d    = pchen_d;
         div_d     = pdiv_d;
         div_cnt_d = pdiv_d;
         pend_d    = 1'b0;
      end else if (bus.en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
         if (wrap) begin
            // A write on the wrap edge goes straight through: pending never asserts.
            sel_d  = psel_d;
            chen_d = pchen_d;
            div_d  = pdiv_d;
            pend_d = 1'b0;
         end else if (bus.cfg_we_i) begin
            pend_d = 1'b1;
         end

         // Reload uses the divider value in force after this edge.
         if (div_cnt_q == '0) begin
            div_cnt_d  = div_d;
            div_tick_d = 1'b1;
         end else begin
            div_cnt_d  = div_cnt_q - DIV_W'(1);
         end

         for (int i = 0; i < NUM_CH; i++) begin
            tick_d[i] = chen_d[i] && tap_hit(cnt_d, int'(sel_d[i*SEL_W +: SEL_W]));
         end
      end else if (bus.cfg_we_i) begin
         // Disabled: counters freeze but a write is still captured for later.
         pend_d = 1'b1;
      end
   end

   // State and output flops; async reset clears all outputs immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q      <= '0;
         div_cnt_q  <= DIV_R;
         sel_q      <= SEL_RST;
         chen_q     <= '1;
         div_q      <= DIV_R;
         psel_q     <= SEL_RST;
         pchen_q    <= '1;
         pdiv_q     <= DIV_R;
         pend_q     <= 1'b0;
         tick_q     <= '0;
         div_tick_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         div_cnt_q  <= div_cnt_d;
         sel_q      <= sel_d;
         chen_q     <= chen_d;
         div_q      <= div_d;
         psel_q     <= psel_d;
         pchen_q    <= pchen_d;
         pdiv_q     <= pdiv_d;
         pend_q     <= pend_d;
         tick_q     <= tick_d;
         div_tick_q <= div_tick_d;
      end
   end

   assign bus.cfg_pend_o = pend_q;
   assign bus.tick_o     = tick_q;
   assign bus.div_tick_o = div_tick_q;

endmodule
